ps2_key_tracker: RTL and testbench

Parametrised PS/2 keyboard front-end for the keyboard synthesiser. It oversamples the raw PS2_CLK/PS2_DAT lines on the system clock and deframes 11-bit device-to-host frames. It decodes make, break (F0) and extended (E0) scan-code sequences and maintains a NUM_KEYS-wide pressed-key bitmap. It emits one-cycle press/release events for the voice/tone logic and drives the debug state output to LEDs.

---
 rtl/ps2_key_tracker.sv | 189 ++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 deframer, scan-code decoder and pressed-key bitmap; define PS2_KEY_TRACKER_PARITY_EN to drop frames with bad odd parity
module ps2_key_tracker #(
  parameter int NUM_KEYS = 32,
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT_CYC = 50000,
  localparam int IW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ps2_clk,
  input  logic                i_ps2_dat,
  output logic [NUM_KEYS-1:0] o_key,
  output logic                o_evt_valid,
  output logic [IW-1:0]       o_evt_idx,
  output logic                o_evt_press,
  output logic [7:0]          o_byte,
  output logic                o_byte_valid,
  output logic                o_frame_err,
  output logic [1:0]          o_state
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic {F_IDLE, F_SHIFT} f_state_t;
  typedef enum logic [1:0] {D_NORM, D_BRK, D_EXT, D_EXTBRK} d_state_t;
  logic clk_s1, clk_s2, dat_s1, dat_s2, filt_lvl, filt_hit, fall, timeout;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  f_state_t f_state, f_next;
  logic [3:0] bit_cnt, bit_next;
  logic [7:0] sh, sh_next;
  logic par_ok, frame_ok, frame_bad;
  d_state_t d_state, d_next;
  logic [31:0] key_r, key_next, onehot;
  logic [5:0] map;
  logic hit, evt_v, evt_p;
  assign filt_hit = (clk_s2 != filt_lvl) && (filt_cnt == FW'(FILT_LEN - 1));
  assign fall = filt_hit & filt_lvl;
  assign timeout = (f_state == F_SHIFT) && (to_cnt == TW'(TIMEOUT_CYC));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'hF;
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
      to_cnt <= '0;
    end else begin
      {clk_s1, clk_s2} <= {i_ps2_clk, clk_s1};
      {dat_s1, dat_s2} <= {i_ps2_dat, dat_s1};
      filt_cnt <= (clk_s2 == filt_lvl || filt_hit) ? '0 : filt_cnt + 1'b1;
      filt_lvl <= filt_hit ? clk_s2 : filt_lvl;
      to_cnt <= fall ? '0 : (to_cnt == TW'(TIMEOUT_CYC) ? to_cnt : to_cnt + 1'b1);
    end
`ifdef PS2_KEY_TRACKER_PARITY_EN
  logic par_acc;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) par_acc <= 1'b0;
    else if (f_state == F_IDLE) par_acc <= 1'b0;
    else if (fall && bit_cnt != 4'd10) par_acc <= par_acc ^ dat_s2;
  assign par_ok = par_acc;
`else
  assign par_ok = 1'b1;
`endif
  always_comb begin
    f_next = f_state;
    bit_next = bit_cnt;
    sh_next = sh;
    frame_ok = 1'b0;
    frame_bad = 1'b0;
    if (f_state == F_IDLE) begin
      if (fall && !dat_s2) begin
        f_next = F_SHIFT;
        bit_next = 4'd1;
      end
    end else if (fall) begin
      if (bit_cnt == 4'd10) begin
        f_next = F_IDLE;
        bit_next = 4'd0;
        frame_ok = dat_s2 & par_ok;
        frame_bad = ~(dat_s2 & par_ok);
      end else begin
        sh_next = (bit_cnt <= 4'd8) ? {dat_s2, sh[7:1]} : sh;
        bit_next = bit_cnt + 4'd1;
      end
    end else if (timeout) begin
      f_next = F_IDLE;
      bit_next = 4'd0;
      frame_bad = 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      f_state <= F_IDLE;
      bit_cnt <= '0;
      sh <= '0;
      o_byte <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      f_state <= f_next;
      bit_cnt <= bit_next;
      sh <= sh_next;
      o_byte <= frame_ok ? sh : o_byte;
      o_byte_valid <= frame_ok;
      o_frame_err <= frame_bad;
    end
  function automatic logic [5:0] key_map(input logic [7:0] c);
    case (c)
      8'h1A: key_map = {1'b1, 5'd0};
      8'h1B: key_map = {1'b1, 5'd1};
      8'h22: key_map = {1'b1, 5'd2};
      8'h23: key_map = {1'b1, 5'd3};
      8'h21: key_map = {1'b1, 5'd4};
      8'h2A: key_map = {1'b1, 5'd5};
      8'h34: key_map = {1'b1, 5'd6};
      8'h32: key_map = {1'b1, 5'd7};
      8'h33: key_map = {1'b1, 5'd8};
      8'h31: key_map = {1'b1, 5'd9};
      8'h3B: key_map = {1'b1, 5'd10};
      8'h3A: key_map = {1'b1, 5'd11};
      8'h15: key_map = {1'b1, 5'd12};
      8'h1E: key_map = {1'b1, 5'd13};
      8'h1D: key_map = {1'b1, 5'd14};
      8'h26: key_map = {1'b1, 5'd15};
      8'h24: key_map = {1'b1, 5'd16};
      8'h2D: key_map = {1'b1, 5'd17};
      8'h2E: key_map = {1'b1, 5'd18};
      8'h2C: key_map = {1'b1, 5'd19};
      8'h36: key_map = {1'b1, 5'd20};
      8'h35: key_map = {1'b1, 5'd21};
      8'h3D: key_map = {1'b1, 5'd22};
      8'h3C: key_map = {1'b1, 5'd23};
      8'h43: key_map = {1'b1, 5'd24};
      8'h46: key_map = {1'b1, 5'd25};
      8'h44: key_map = {1'b1, 5'd26};
      8'h45: key_map = {1'b1, 5'd27};
      8'h4D: key_map = {1'b1, 5'd28};
      8'h41: key_map = {1'b1, 5'd29};
      8'h4B: key_map = {1'b1, 5'd30};
      8'h49: key_map = {1'b1, 5'd31};
      default: key_map = 6'd0;
    endcase
  endfunction
  assign map = key_map(o_byte);
  assign hit = map[5] && (int'(map[4:0]) < NUM_KEYS);
  assign onehot = hit ? (32'd1 << map[4:0]) : 32'd0;
  // decode consumes the byte in the cycle o_byte_valid is high
  always_comb begin
    d_next = d_state;
    key_next = key_r;
    evt_v = 1'b0;
    evt_p = 1'b0;
    if (o_byte_valid)
      case (d_state)
        D_NORM:
          if (o_byte == 8'hE0) d_next = D_EXT;
          else if (o_byte == 8'hF0) d_next = D_BRK;
          else if (o_byte == 8'hAA) key_next = '0;
          else if (|(onehot & ~key_r)) begin
            key_next = key_r | onehot;
            evt_v = 1'b1;
            evt_p = 1'b1;
          end
        D_BRK: begin
          d_next = D_NORM;
          if (|(onehot & key_r)) begin
            key_next = key_r & ~onehot;
            evt_v = 1'b1;
          end
        end
        D_EXT: d_next = (o_byte == 8'hF0) ? D_EXTBRK : D_NORM;
        default: d_next = D_NORM;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      d_state <= D_NORM;
      key_r <= '0;
      o_evt_valid <= 1'b0;
      o_evt_press <= 1'b0;
      o_evt_idx <= '0;
    end else begin
      d_state <= d_next;
      key_r <= key_next;
      o_evt_valid <= evt_v;
      o_evt_press <= evt_p;
      o_evt_idx <= evt_v ? map[IW-1:0] : o_evt_idx;
    end
  assign o_key = key_r[NUM_KEYS-1:0];
  assign o_state = d_state;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: drives PS/2 frames into 32-key and 16-key trackers and checks them against a scan-code model
module tb_ps2_key_tracker;
  localparam int FL = 4, TO = 300, HALF = 25, GAP = 40;
  logic i_clk = 1'b0, i_rst_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic [31:0] key32;
  logic [15:0] key16;
  logic ev32_v, ev32_p, ev16_v, ev16_p, bv32, bv16, fe32, fe16;
  logic [4:0] ev32_i;
  logic [3:0] ev16_i;
  logic [7:0] byte32, byte16;
  logic [1:0] st32, st16;
  int tests = 0, fails = 0, cyc = 0, bv_cyc = -100, err32 = 0, err16 = 0;
  int got32[$], got16[$], exp_ev[$];
  logic [7:0] got_bytes[$];
  logic [31:0] m_key;
  logic [7:0] m_byte;
  bit m_ext, m_brk;
  logic [7:0] codes [32] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31,
    8'h3B, 8'h3A, 8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D,
    8'h3C, 8'h43, 8'h46, 8'h44, 8'h45, 8'h4D, 8'h41, 8'h4B, 8'h49};

  ps2_key_tracker #(.NUM_KEYS(32), .FILT_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
    .o_key(key32), .o_evt_valid(ev32_v), .o_evt_idx(ev32_i), .o_evt_press(ev32_p),
    .o_byte(byte32), .o_byte_valid(bv32), .o_frame_err(fe32), .o_state(st32));
  ps2_key_tracker #(.NUM_KEYS(16), .FILT_LEN(FL), .TIMEOUT_CYC(TO)) dut16 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
    .o_key(key16), .o_evt_valid(ev16_v), .o_evt_idx(ev16_i), .o_evt_press(ev16_p),
    .o_byte(byte16), .o_byte_valid(bv16), .o_frame_err(fe16), .o_state(st16));

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    cyc++;
    if (bv32) begin
      got_bytes.push_back(byte32);
      bv_cyc = cyc;
    end
    if (fe32) err32++;
    if (fe16) err16++;
    if (ev32_v) begin
      got32.push_back(ev32_p * 64 + int'(ev32_i));
      chk("evt32_latency", cyc - bv_cyc, 1);
      chk("evt32_key", key32[ev32_i], ev32_p);
    end
    if (ev16_v) begin
      got16.push_back(ev16_p * 64 + int'(ev16_i));
      chk("evt16_latency", cyc - bv_cyc, 1);
      chk("evt16_key", key16[ev16_i], ev16_p);
    end
  end

  function automatic int idx_of(input logic [7:0] b);
    foreach (codes[i]) if (codes[i] == b) return i;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k = idx_of(b);
    m_byte = b;
    if (m_ext) begin
      if (!m_brk && b == 8'hF0) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      m_brk = 0;
      if (k >= 0 && m_key[k]) begin m_key[k] = 1'b0; exp_ev.push_back(k); end
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hAA) m_key = '0;
    else if (k >= 0 && !m_key[k]) begin m_key[k] = 1'b1; exp_ev.push_back(64 + k); end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input bit badp);
    return {1'b1, (~^b) ^ badp, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic check_all(input string tag, input int n_bytes, input int n_err, input int e32, input int e16);
    int exp16[$];
    foreach (exp_ev[i]) if (exp_ev[i] % 64 < 16) exp16.push_back(exp_ev[i]);
    chk({tag, "/bytes"}, got_bytes.size(), n_bytes);
    chk({tag, "/err32"}, err32 - e32, n_err);
    chk({tag, "/err16"}, err16 - e16, n_err);
    chk({tag, "/byte32"}, byte32, m_byte);
    chk({tag, "/byte16"}, byte16, m_byte);
    chk({tag, "/key32"}, key32, m_key);
    chk({tag, "/key16"}, key16, m_key[15:0]);
    chk({tag, "/state32"}, st32, {m_ext, m_brk});
    chk({tag, "/state16"}, st16, {m_ext, m_brk});
    chk({tag, "/nevt32"}, got32.size(), exp_ev.size());
    chk({tag, "/nevt16"}, got16.size(), exp16.size());
    for (int i = 0; i < got32.size() && i < exp_ev.size(); i++) chk({tag, "/evt32"}, got32[i], exp_ev[i]);
    for (int i = 0; i < got16.size() && i < exp16.size(); i++) chk({tag, "/evt16"}, got16[i], exp16[i]);
    got32.delete();
    got16.delete();
    exp_ev.delete();
    got_bytes.delete();
  endtask

  task automatic step(input string tag, input logic [7:0] b, input bit badp);
    int e32 = err32, e16 = err16;
    bit accept = 1;
`ifdef PS2_KEY_TRACKER_PARITY_EN
    accept = !badp;
`endif
    send_bits(frame(b, badp), 11);
    wait_cyc(GAP);
    if (accept) model_byte(b);
    check_all(tag, int'(accept), int'(!accept), e32, e16);
  endtask

  initial begin
    int e32, e16, r;
    logic [7:0] rb;
    logic [7:0] unm [3] = '{8'h75, 8'h5A, 8'h12};
    m_key = '0;
    m_byte = '0;
    wait_cyc(5);
    chk("reset_outs", {key32, key16, ev32_v, ev16_v, bv32, bv16, fe32, fe16, byte32, byte16, st32, st16, ev32_i, ev16_i, ev32_p, ev16_p}, '0);
    i_rst_n = 1'b1;
    wait_cyc(10);
    step("make15", 8'h15, 0);
    chk("make15_byte", byte32, 8'h15);
    step("repeat15", 8'h15, 0);
    step("f0", 8'hF0, 0);
    step("brk15", 8'h15, 0);
    step("ext_e0", 8'hE0, 0);
    step("ext_75", 8'h75, 0);
    step("ext_e0b", 8'hE0, 0);
    step("ext_f0", 8'hF0, 0);
    step("ext_brk75", 8'h75, 0);
    step("oor_4d", 8'h4D, 0);
    step("k1a", 8'h1A, 0);
    step("k1a_rep", 8'h1A, 0);
    step("k22", 8'h22, 0);
    chk("plan_key16", key16, 16'h0005);
    e32 = err32;
    e16 = err16;
    send_bits(frame(8'h1B, 0), 5);
    wait_cyc(TO + 100);
    check_all("timeout", 0, 1, e32, e16);
    step("after_to_1b", 8'h1B, 0);
    step("bad_par15", 8'h15, 1);
    send_bits(frame(8'h22, 0), 5);
    wait_cyc(3);
    i_rst_n = 1'b0;
    wait_cyc(3);
    chk("midreset_outs", {key32, key16, ev32_v, ev16_v, bv32, bv16, fe32, fe16, byte32, byte16, st32, st16, ev32_i, ev16_i, ev32_p, ev16_p}, '0);
    m_key = '0;
    m_byte = '0;
    m_ext = 0;
    m_brk = 0;
    got32.delete();
    got16.delete();
    got_bytes.delete();
    wait_cyc(10);
    i_rst_n = 1'b1;
    wait_cyc(10);
    step("post_reset_1a", 8'h1A, 0);
    repeat (30) begin
      r = int'($urandom_range(0, 9));
      rb = r <= 5 ? codes[$urandom_range(0, 31)] : r == 6 ? 8'hF0 : r == 7 ? 8'hE0 :
           r == 8 ? unm[$urandom_range(0, 2)] : ($urandom_range(0, 3) == 0 ? 8'hAA : 8'hF0);
      step("rand", rb, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
